// File: rtl/antares_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// antares_arb_mux_pkg
//   Shared definitions for the Antares parametrised blocks:
//     - arbitration mode encodings (ARB_RR, ARB_FIXED)
//     - clog2 / sel_width helpers used to size channel index fields
// -----------------------------------------------------------------------------
package antares_arb_mux_pkg;

    localparam int unsigned ARB_RR    = 0;  // round-robin
    localparam int unsigned ARB_FIXED = 1;  // fixed priority, lowest index wins

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Index field width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/antares_rr_arbiter.sv
// -----------------------------------------------------------------------------
// antares_rr_arbiter
//   Grant logic for antares_arb_mux. Produces a one-hot grant and its encoded
//   index from a request vector, qualified by an enable. Holds the round-robin
//   "last granted" pointer.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req_i      per-channel request vector
//   en_i       grant enable (output register can accept a beat)
//   gnt_o      one-hot grant, all zeros when disabled or no request
//   gnt_idx_o  encoded index of the winning request
// -----------------------------------------------------------------------------
module antares_rr_arbiter
    import antares_arb_mux_pkg::*;
#(
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  ARB_MODE = ARB_RR,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_i,
    input  logic                en_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [SEL_W-1:0]    gnt_idx_o
);

    // One extra bit so last + offset cannot overflow before the wrap.
    localparam logic [SEL_W:0]   NUM_CH    = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0]   cand;
    logic             found;

    always_comb begin
        idx   = '0;
        cand  = '0;
        found = |req_i;
        if (ARB_MODE == ARB_FIXED) begin
            // Descending scan: the lowest valid index is assigned last and wins.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan offsets from CHANNELS down to 1 so the nearest channel after
            // last is assigned last and wins; offset CHANNELS is last itself.
            for (int off = CHANNELS; off >= 1; off--) begin
                cand = {1'b0, last_q} + (SEL_W+1)'(off);
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                if (req_i[cand[SEL_W-1:0]]) begin
                    idx = cand[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gnt_o[i] = en_i & found & (idx == SEL_W'(i));
        end
    end

    assign gnt_idx_o = idx;

    // Any enabled cycle with a request is a real transfer on the granted channel.
    always_comb begin
        last_d = last_q;
        if ((ARB_MODE == ARB_RR) && en_i && found) begin
            last_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= LAST_INIT;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/antares_arb_mux.sv
// -----------------------------------------------------------------------------
// antares_arb_mux
//   N-channel arbitrated multiplexer with valid/ready handshakes and a single
//   registered output beat tagged with its source channel.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   in_data      packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (combinational, at most one bit set)
//   out_data     registered selected data
//   out_channel  registered source channel index
//   out_valid    registered output valid
//   out_ready    downstream ready
// -----------------------------------------------------------------------------
module antares_arb_mux
    import antares_arb_mux_pkg::*;
#(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  ARB_MODE = ARB_RR,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_channel_q, out_channel_d;
    logic             out_valid_q, out_valid_d;

    logic                load;
    logic                any_valid;
    logic [CHANNELS-1:0] gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    ch_data [CHANNELS];

    // Register is free when empty or being drained this cycle.
    assign load      = ~out_valid_q | out_ready;
    assign any_valid = |in_valid;

    antares_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req_i     (in_valid),
        .en_i      (load),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign in_ready = gnt;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        if (load) begin
            out_valid_d = any_valid;
            // Data and channel keep their last values when nothing is accepted.
            if (any_valid) begin
                out_data_d    = ch_data[gnt_idx];
                out_channel_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule
